// File: rtl/fitbit_pkg.sv
// Purpose : shared definitions for the step pulse generator (state codes, default widths).
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: step FSM state type and encodings, default counter/timer widths.
package fitbit_pkg;

  // Default widths; CNT_W matches the stepCounter count width.
  localparam int CNT_W_DFLT = 20;
  localparam int TIM_W_DFLT = 32;

  // Step FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t HIGH = 2'd1;
  localparam state_t LOW  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/phase_timer.sv
// Purpose : loadable down-counter that times one FSM phase; expires on the cycle it reads 1.
// Latency : a load of N makes expire_o assert N cycles after the load cycle (N >= 1).
// Backpressure: none; free-running once loaded, holds at 0 when not reloaded.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   load_i          reload the counter with value_i on the next edge
//   value_i         phase length in cycles
//   expire_o        high during the last cycle of the phase (count == 1)
module phase_timer #(
  parameter int TIM_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TIM_W-1:0] value_i,
  output logic             expire_o
);

  logic [TIM_W-1:0] cnt_q;
  logic [TIM_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      // Stops at 0 so a stale count can never wrap and re-expire while idle.
      cnt_d = cnt_q - TIM_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TIM_W'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// Purpose : programmable step-pulse train (finite burst or continuous) for demo/self-test.
// Latency : X rises 1 cycle after an accepted start; all outputs come straight from flops.
// Backpressure: none; start is ignored while busy, stop aborts without truncating a pulse.
// Ports:
//   clk100MHz, reset   100 MHz clock, asynchronous active-low reset
//   start, stop        one-cycle control pulses (stop wins when both are high)
//   period_cyc         cycles between rising edges of X (sanitised to >= 2)
//   high_cyc           cycles X is high per step (clamped to 1..period-1)
//   num_steps          burst length, 0 = continuous
//   X                  registered step pulse
//   busy, done         state != IDLE; one-cycle pulse when a finite burst completes
//   steps_sent         rising edges of X since the last accepted start
module step_pulse_gen
  import fitbit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT,
  parameter int TIM_W = TIM_W_DFLT
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [TIM_W-1:0] period_cyc,
  input  logic [TIM_W-1:0] high_cyc,
  input  logic [CNT_W-1:0] num_steps,
  output logic             X,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_sent
);

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;

  // Latched (sanitised) configuration.
  logic [TIM_W-1:0] high_q, high_d;
  logic [TIM_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] num_q, num_d;

  logic [CNT_W-1:0] steps_q, steps_d;
  logic             stop_pend_q, stop_pend_d;

  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [TIM_W-1:0] period_eff;
  logic [TIM_W-1:0] high_eff;
  logic [TIM_W-1:0] low_eff;

  logic             accept;
  logic             finite;
  logic             enter_high;
  logic             enter_low;
  logic             tmr_load;
  logic [TIM_W-1:0] tmr_value;
  logic             tmr_expire;

  // ---------------------------------------------------------------------
  // Config sanitising (evaluated on the live inputs, latched on accept)
  // ---------------------------------------------------------------------
  always_comb begin
    period_eff = (period_cyc < TIM_W'(2)) ? TIM_W'(2) : period_cyc;
    if (high_cyc == '0) begin
      high_eff = TIM_W'(1);
    end else if (high_cyc >= period_eff) begin
      high_eff = period_eff - TIM_W'(1);
    end else begin
      high_eff = high_cyc;
    end
    // Always >= 1 because high_eff <= period_eff - 1.
    low_eff = period_eff - high_eff;
  end

  // stop has priority over start in the same cycle.
  assign accept = (state_q == IDLE) && start && !stop;
  assign finite = (num_q != '0);

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        // A stop seen at any point of the pulse is honoured only once the
        // pulse has run its full width, so no truncated step ever leaves.
        if (tmr_expire) begin
          state_d = (stop || stop_pend_q) ? IDLE : LOW;
        end
      end
      LOW: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tmr_expire) begin
          state_d = (finite && (steps_q == num_q)) ? DONE : HIGH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs, computed from the next state so the flops line up with
  // the state register and X is glitch-free.
  // ---------------------------------------------------------------------
  always_comb begin
    x_d    = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  assign enter_high = (state_d == HIGH) && (state_q != HIGH);
  assign enter_low  = (state_d == LOW)  && (state_q != LOW);

  always_comb begin
    high_d = high_q;
    low_d  = low_q;
    num_d  = num_q;
    if (accept) begin
      high_d = high_eff;
      low_d  = low_eff;
      num_d  = num_steps;
    end
  end

  // Remember a stop that arrives mid-pulse; cleared as soon as HIGH is left.
  assign stop_pend_d = (state_d == HIGH) && (stop_pend_q || stop);

  always_comb begin
    steps_d = steps_q;
    if (accept) begin
      // Clear and count the first pulse in one go.
      steps_d = CNT_W'(1);
    end else if (enter_high && (steps_q != '1)) begin
      // Saturating count; only reachable in continuous mode.
      steps_d = steps_q + CNT_W'(1);
    end
  end

  // The timer is reloaded on every phase entry; on the accepting cycle the
  // latched high time is not yet valid, so the sanitised input is used.
  assign tmr_load  = enter_high || enter_low;
  assign tmr_value = enter_high ? (accept ? high_eff : high_q) : low_q;

  always_ff @(posedge clk100MHz or negedge reset) begin
    if (!reset) begin
      high_q      <= '0;
      low_q       <= '0;
      num_q       <= '0;
      steps_q     <= '0;
      stop_pend_q <= 1'b0;
      x_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      high_q      <= high_d;
      low_q       <= low_d;
      num_q       <= num_d;
      steps_q     <= steps_d;
      stop_pend_q <= stop_pend_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  phase_timer #(
    .TIM_W (TIM_W)
  ) u_phase_timer (
    .clk_i    (clk100MHz),
    .rst_ni   (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  assign X          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_sent = steps_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed trains plus randomized bursts/stops,
// checked cycle by cycle against an arithmetic model of the pulse train.
module tb_step_pulse_gen;

  localparam int CNT_W = 20;
  localparam int TIM_W = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic [TIM_W-1:0] period_cyc;
  logic [TIM_W-1:0] high_cyc;
  logic [CNT_W-1:0] num_steps;
  logic             X;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_sent;

  int checks   = 0;
  int failures = 0;

  step_pulse_gen #(
    .CNT_W (CNT_W),
    .TIM_W (TIM_W)
  ) dut (
    .clk100MHz  (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .period_cyc (period_cyc),
    .high_cyc   (high_cyc),
    .num_steps  (num_steps),
    .X          (X),
    .busy       (busy),
    .done       (done),
    .steps_sent (steps_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " X"}, 32'(X), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " steps"}, 32'(steps_sent), 0);
  endtask

  function automatic int eff_period(input int pc);
    return (pc < 2) ? 2 : pc;
  endfunction

  function automatic int eff_high(input int hc, input int pe);
    return (hc < 1) ? 1 : ((hc > pe - 1) ? pe - 1 : hc);
  endfunction

  // Start a train in the current cycle (cycle 0) and check cycles 1..ncyc.
  // Model: step k occupies cycles k*pe+1 .. (k+1)*pe, high for the first he
  // of them. sa = cycle stop is pulsed (0 = never), ra = cycle a second
  // start with junk config is pulsed while busy (0 = never).
  task automatic run_train(input int pc, input int hc, input int ns,
                           input int sa, input int ra, input int ncyc,
                           input string tag);
    int pe, he, aend, k, ph;
    int ex, eb, ed, es;
    int edges_dut, edges_mdl, prev_dut, prev_mdl;
    bit finite, stopped;
    pe      = eff_period(pc);
    he      = eff_high(hc, pe);
    finite  = (ns > 0);
    stopped = (sa > 0);
    if (stopped) begin
      k  = (sa - 1) / pe;
      ph = (sa - 1) % pe;
      aend = (ph < he) ? (k * pe + he) : sa;
    end else if (finite) begin
      aend = ns * pe;
    end else begin
      aend = ncyc + 1;
    end

    period_cyc = TIM_W'(pc);
    high_cyc   = TIM_W'(hc);
    num_steps  = CNT_W'(ns);
    start      = 1'b1;
    stop       = 1'b0;
    edges_dut = 0; edges_mdl = 0; prev_dut = 0; prev_mdl = 0;

    for (int t = 1; t <= ncyc; t++) begin
      tick();
      if (t <= aend) begin
        ex = ((t - 1) % pe < he) ? 1 : 0;
        eb = 1; ed = 0; es = (t - 1) / pe + 1;
      end else if (!stopped && finite && t == aend + 1) begin
        ex = 0; eb = 1; ed = 1; es = ns;
      end else begin
        ex = 0; eb = 0; ed = 0; es = (aend - 1) / pe + 1;
      end
      chk($sformatf("%s c%0d X", tag, t), 32'(X), ex);
      chk($sformatf("%s c%0d busy", tag, t), 32'(busy), eb);
      chk($sformatf("%s c%0d done", tag, t), 32'(done), ed);
      chk($sformatf("%s c%0d steps", tag, t), 32'(steps_sent), es);
      if (X && prev_dut == 0) edges_dut++;
      if (ex == 1 && prev_mdl == 0) edges_mdl++;
      prev_dut = int'(X);
      prev_mdl = ex;
      // Inputs for cycle t: config is scrambled so only the latched copy matters.
      start      = (t == ra);
      stop       = (t == sa);
      period_cyc = $urandom;
      high_cyc   = $urandom;
      num_steps  = CNT_W'($urandom);
    end
    start = 1'b0;
    stop  = 1'b0;
    chk({tag, " rising_edges"}, edges_dut, edges_mdl);
  endtask

  initial begin
    int pc, hc, ns, pe, sa, ra, lim;
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    period_cyc = '0; high_cyc = '0; num_steps = '0;

    // Reset held with start pulsing: everything stays at zero.
    #1;
    for (int i = 0; i < 4; i++) begin
      period_cyc = 6; high_cyc = 2; num_steps = 3;
      start = i[0];
      tick();
      chk_idle_zero($sformatf("reset_hold%0d", i));
    end
    start = 1'b0;
    reset = 1'b1;

    // Burst: X high in 1-2, 7-8, 13-14; done in 19; start in cycle 5 ignored.
    run_train(6, 2, 3, 0, 5, 22, "burst");
    // Clamping: period 1 -> 2, high 5 -> 1.
    run_train(1, 5, 2, 0, 0, 8, "clamp");
    // Continuous, stop in cycle 122 (inside the 11th pulse, cycles 121-126).
    run_train(12, 6, 0, 122, 40, 132, "contin");
    // Burst of 25 as it would feed the step counter.
    run_train(3, 1, 25, 0, 0, 80, "loop25");

    // start and stop together while idle: nothing happens.
    period_cyc = 4; high_cyc = 2; num_steps = 1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_same X", 32'(X), 0);
    chk("ss_same busy", 32'(busy), 0);
    tick();
    chk("ss_same busy2", 32'(busy), 0);

    // Reset asserted in LOW of step 2 (period 6, high 2 -> LOW in 9..12).
    period_cyc = 6; high_cyc = 2; num_steps = 5;
    start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      start = 1'b0;
    end
    chk("midrst pre X", 32'(X), 0);
    chk("midrst pre busy", 32'(busy), 1);
    chk("midrst pre steps", 32'(steps_sent), 2);
    reset = 1'b0;
    #1;
    chk_idle_zero("midrst now");
    for (int i = 0; i < 3; i++) begin
      start = ~i[0];
      tick();
      chk_idle_zero($sformatf("midrst hold%0d", i));
    end
    start = 1'b0;
    reset = 1'b1;
    tick();

    // Randomized trains, with random aborts and restarts-while-busy.
    for (int i = 0; i < 10; i++) begin
      pc = $urandom_range(0, 8);
      hc = $urandom_range(0, 9);
      ns = $urandom_range(0, 4);
      pe = eff_period(pc);
      if (ns == 0) begin
        sa  = $urandom_range(1, 3 * pe);
        lim = 4 * pe + 4;
      end else begin
        sa  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ns * pe) : 0;
        lim = ns * pe + 4;
      end
      ra = $urandom_range(1, (sa > 0) ? sa : ns * pe);
      run_train(pc, hc, ns, sa, ra, lim, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
